mvb_frame_parser: RTL
=====================

MVB_FRAME_PARSER -- requirements
Module: mvb_frame_parser

Interface
REQ-001 SHALL use one clock and one reset; reset is asynchronous and active-low.
REQ-002 SHALL expose the following ports (clock and reset first):
- clk  in  1  24 MHz system clock; same clock as the decoder FIFO read side.
- rst  in  1  asynchronous active-low reset.
- frame_over  in  1  decoder frame-end level, synchronous to clk.
- frame_is_master  in  1  1 = decoded frame was a master frame; valid while frame_over=1.
- frame_error  in  1  OR of decoder length, signal, delimiter, quality and crc errors; valid while frame_over=1.
- fifo_empty  in  1  decoder FIFO empty.
- fifo_data  in  16  decoder FIFO dout; valid 1 clk after fifo_rden.
- fifo_rden  out  1  decoder FIFO read enable.
- buf_addr  in  4  slave-data buffer read address.
- buf_rdata  out  16  buffer word at buf_addr, registered, 1 clk latency.
- mf_valid  out  1  1-clk pulse: master frame accepted.
- f_code  out  4  F_code of the last accepted master frame.
- address  out  12  address of the last accepted master frame.
- sf_valid  out  1  1-clk pulse: slave frame accepted.
- sf_words  out  5  word count of the last accepted slave frame (1..16).
- err_frame  out  1  1-clk pulse: frame discarded because of a decoder error.
- err_length  out  1  1-clk pulse: word count mismatch, or slave frame with no valid expectation.
- err_overrun  out  1  1-clk pulse: a new frame_over rising edge arrived while busy.
- busy  out  1  1 in any state other than IDLE.

Function
REQ-003 SHALL implement the states IDLE, SETTLE, DRAIN, CHECK.
REQ-004 IDLE -> SETTLE on a frame_over rising edge (frame_over=1 and its registered copy=0); on that edge it SHALL latch frame_is_master and frame_error, and clear the word counter and overrun flag.
REQ-005 SETTLE SHALL wait exactly 8 clk cycles (3-bit counter), to absorb FIFO cross-clock latency, then go to DRAIN.
REQ-006 DRAIN SHALL assert fifo_rden for one cycle whenever fifo_empty=0 and no read is outstanding, giving at most one read every 2 clks.
REQ-007 Each returned word SHALL be written to buffer[count] while count<16; count SHALL saturate at 31; words beyond 16 SHALL be dropped.
REQ-008 The first word of every frame SHALL also be held in a 16-bit shadow register.
REQ-009 DRAIN -> CHECK when fifo_empty=1 and no read is outstanding.
REQ-010 CHECK SHALL last 1 clk, produce exactly one result pulse, and then return to IDLE. Results are evaluated in this priority order:
- overrun flag set -> err_overrun.
- latched frame_error -> err_frame.
- master frame, count==1 -> mf_valid; f_code<=shadow[15:12], address<=shadow[11:0], set master_seen.
- master frame, count!=1 -> err_length.
- slave frame, master_seen=1, f_code<=4, count==(1<<f_code) -> sf_valid; sf_words<=count; clear master_seen.
- any other slave frame -> err_length; clear master_seen.
REQ-011 A frame_over rising edge in SETTLE, DRAIN or CHECK SHALL set the overrun flag and SHALL NOT restart the state machine.
REQ-012 A decoder FIFO holding 0 words at DRAIN entry SHALL yield count=0; this is an err_length result, or err_frame if frame_error was latched.
REQ-013 The buffer SHALL be 16x16, single write port, and read via buf_addr with 1 clk registered latency. Reads during DRAIN return partially overwritten data; consumers use the buffer only after sf_valid.
REQ-014 f_code, address and sf_words SHALL hold their values until the next accepted frame of the same type.
REQ-015 A read SHALL be counted as outstanding from the fifo_rden cycle until fifo_data is captured on the next clk.

Reset
REQ-016 While rst=0 the block SHALL hold:
- state=IDLE.
- all counters and flags 0, including master_seen and overrun.
- fifo_rden, mf_valid, sf_valid, err_frame, err_length, err_overrun and busy all 0.
- f_code=0, address=0, sf_words=0, buf_rdata=0.
- buffer contents unspecified.
REQ-017 Reset asserted mid-frame SHALL abort immediately with no result pulse; after release the block SHALL wait for a fresh frame_over rising edge, ignoring a frame_over level that is already high.

Verification
REQ-018 Master frame: FIFO holds 0x3123, frame_is_master=1, frame_error=0 -> one fifo_rden, mf_valid pulse, f_code=3, address=0x123, busy low within 15 clks after the FIFO empties.
REQ-019 Matching slave frame: after REQ-018, a slave frame of words 0x0001..0x0008 -> sf_valid, sf_words=8, and buf_addr=7 gives buf_rdata=0x0008 one clk later.
REQ-020 Mismatched slave frame: after master f_code=1, a slave frame of 3 words -> err_length, no sf_valid; a following slave frame of 2 words -> err_length because master_seen is cleared.
REQ-021 Decoder error: master frame with frame_error=1 -> FIFO fully drained, err_frame pulse, f_code and address unchanged.
REQ-022 Long slave frame: after master f_code=4, a slave frame of 17 words -> buffer keeps the first 16 words, count=17, err_length.
REQ-023 Boundaries and reset:
- a second frame_over rising edge during DRAIN -> err_overrun.
- rst=0 during DRAIN -> all outputs 0, with no pulse after release.

Source files
------------

// File: rtl/mvb_frame_parser.sv
// -----------------------------------------------------------------------------
// mvb_frame_parser
//
// Turns a decoded MVB frame into one result pulse. The decoder signals the end
// of a frame with the frame_over level; this block then waits for the decoder
// FIFO to settle and drains it one word at a time. The first word goes into a
// shadow register and the first 16 words go into a 16x16 buffer. The word count
// and frame type are then checked against the last accepted master frame.
//
// Ports
//   clk              system clock (also the decoder FIFO read clock)
//   rst              asynchronous active-low reset
//   frame_over       decoder frame-end level; a rising edge starts a frame
//   frame_is_master  frame type, valid while frame_over=1
//   frame_error      any decoder error, valid while frame_over=1
//   fifo_empty       decoder FIFO empty
//   fifo_data        decoder FIFO dout, valid 1 clk after fifo_rden
//   fifo_rden        decoder FIFO read enable
//   buf_addr         slave-data buffer read address
//   buf_rdata        buffer word at buf_addr, registered, 1 clk latency
//   mf_valid         pulse: master frame accepted (f_code/address updated)
//   f_code, address  fields of the last accepted master frame
//   sf_valid         pulse: slave frame accepted (sf_words updated)
//   sf_words         word count of the last accepted slave frame
//   err_frame        pulse: frame discarded because of a decoder error
//   err_length       pulse: word count mismatch / unexpected slave frame
//   err_overrun      pulse: new frame_over edge arrived while busy
//   busy             high in every state except IDLE
//
// FIFO read handshake: in DRAIN, fifo_rden is high for one cycle when
// fifo_empty=0 and no read is outstanding. The read stays outstanding until
// fifo_data is captured on the following clk. So there is at most one read
// every two clocks, and fifo_empty is always sampled after the previous pop.
// -----------------------------------------------------------------------------
module mvb_frame_parser (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_over,
  input  logic        frame_is_master,
  input  logic        frame_error,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_rden,
  input  logic [3:0]  buf_addr,
  output logic [15:0] buf_rdata,
  output logic        mf_valid,
  output logic [3:0]  f_code,
  output logic [11:0] address,
  output logic        sf_valid,
  output logic [4:0]  sf_words,
  output logic        err_frame,
  output logic        err_length,
  output logic        err_overrun,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DRAIN  = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        fo_q;
  logic        fo_rise;
  logic        lat_master;
  logic        lat_error;
  logic        overrun;
  logic        master_seen;
  logic        rd_pend;
  logic [2:0]  settle_cnt;
  logic [4:0]  word_cnt;
  logic [15:0] shadow;
  logic [4:0]  sf_expect;
  logic [15:0] mem [16];

  // Result decisions, valid only in CHECK; registered into the pulse outputs
  // so each pulse appears together with its updated data fields.
  logic        res_mf;
  logic        res_sf;
  logic        res_ef;
  logic        res_el;
  logic        res_eo;

  assign fo_rise   = frame_over & ~fo_q;
  // Only meaningful for f_code<=4; larger codes are rejected before use.
  assign sf_expect = 5'd1 << f_code;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fo_rise) state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == 3'd7) state_nxt = S_DRAIN;
      S_DRAIN:  if (fifo_empty && !rd_pend) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    fifo_rden = 1'b0;
    busy      = (state != S_IDLE);
    res_mf    = 1'b0;
    res_sf    = 1'b0;
    res_ef    = 1'b0;
    res_el    = 1'b0;
    res_eo    = 1'b0;
    if (state == S_DRAIN && !fifo_empty && !rd_pend) fifo_rden = 1'b1;
    if (state == S_CHECK) begin
      if (overrun)                 res_eo = 1'b1;
      else if (lat_error)          res_ef = 1'b1;
      else if (lat_master) begin
        if (word_cnt == 5'd1)      res_mf = 1'b1;
        else                       res_el = 1'b1;
      end else if (master_seen && f_code <= 4'd4 && word_cnt == sf_expect)
                                   res_sf = 1'b1;
      else                         res_el = 1'b1;
    end
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // The edge detector history resets high, so a frame_over level that
      // is already high at reset release is not taken as a new frame.
      fo_q        <= 1'b1;
      lat_master  <= 1'b0;
      lat_error   <= 1'b0;
      overrun     <= 1'b0;
      master_seen <= 1'b0;
      rd_pend     <= 1'b0;
      settle_cnt  <= 3'd0;
      word_cnt    <= 5'd0;
      shadow      <= 16'd0;
      mf_valid    <= 1'b0;
      sf_valid    <= 1'b0;
      err_frame   <= 1'b0;
      err_length  <= 1'b0;
      err_overrun <= 1'b0;
      f_code      <= 4'd0;
      address     <= 12'd0;
      sf_words    <= 5'd0;
    end else begin
      fo_q <= frame_over;

      if (state == S_IDLE && fo_rise) begin
        lat_master <= frame_is_master;
        lat_error  <= frame_error;
        overrun    <= 1'b0;
      end else if (state != S_IDLE && fo_rise) begin
        overrun <= 1'b1;
      end

      if (state == S_SETTLE) settle_cnt <= settle_cnt + 3'd1;
      else                   settle_cnt <= 3'd0;

      rd_pend <= fifo_rden;

      if (state == S_IDLE && fo_rise) begin
        word_cnt <= 5'd0;
      end else if (rd_pend) begin
        if (word_cnt == 5'd0) shadow <= fifo_data;
        // Saturate so an over-long frame can never wrap back to a legal count.
        if (word_cnt != 5'd31) word_cnt <= word_cnt + 5'd1;
      end

      mf_valid    <= res_mf;
      sf_valid    <= res_sf;
      err_frame   <= res_ef;
      err_length  <= res_el;
      err_overrun <= res_eo;

      if (res_mf) begin
        f_code      <= shadow[15:12];
        address     <= shadow[11:0];
        master_seen <= 1'b1;
      end
      if (res_sf) begin
        sf_words    <= word_cnt;
        master_seen <= 1'b0;
      end
      // Any rejected slave frame also consumes the pending expectation.
      if (res_el && !lat_master) master_seen <= 1'b0;
    end
  end

  // ------------------------------------------------------------------- buffer
  // Words past the 16th are dropped; word_cnt still counts them.
  always_ff @(posedge clk) begin
    if (rd_pend && word_cnt < 5'd16) mem[word_cnt[3:0]] <= fifo_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) buf_rdata <= 16'd0;
    else      buf_rdata <= mem[buf_addr];
  end

endmodule
